// File: rtl/seg_scan_mux.sv
`timescale 1ns/1ps
// seg_scan_mux
// Multiplexes four hex digits onto a shared 7-segment decoder. A prescaler
// sets the dwell time per digit. A 2-bit index walks the digits 0..3.
// Data captured with LOAD waits in a pending register. It is copied into
// the display register only at a frame boundary, so a frame never shows a
// mix of old and new digits.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, leading digits 3..1 are blanked if they are zero and
//   carry no decimal point from that digit upward. Digit 0 is never blanked.
//
// Ports
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   load     one-cycle strobe; captures data/dp_in
//   data     four hex digits; digit k = data[4k+3:4k]
//   dp_in    decimal-point request per digit, 1 = lit
//   an       digit enables, active-low, at most one low
//   x        nibble of the active digit (to the hex-to-segment decoder)
//   dp       decimal point of the active digit, active-low
//   blank    1 = current slot blanked
//   pend     1 = captured value waiting for the frame boundary
module seg_scan_mux #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [3:0]  x,
    output logic        dp,
    output logic        blank,
    output logic        pend
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   disp_data;
    logic [3:0]    disp_dp;
    logic [15:0]   pend_data;
    logic [3:0]    pend_dp;
    logic          tick;
    logic          frame_end;
    logic          slot_blank;

    assign tick      = (presc == PRESC_LAST);
    assign frame_end = tick && (idx == 2'd3);

    // At a frame boundary a LOAD in the same cycle wins over an older pending
    // value and goes straight to the display. Outside a boundary, LOAD only
    // overwrites the pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= 2'd0;
            disp_data <= 16'h0000;
            disp_dp   <= 4'h0;
            pend_data <= 16'h0000;
            pend_dp   <= 4'h0;
            pend      <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                if (load) begin
                    disp_data <= data;
                    disp_dp   <= dp_in;
                    pend      <= 1'b0;
                end else if (pend) begin
                    disp_data <= pend_data;
                    disp_dp   <= pend_dp;
                    pend      <= 1'b0;
                end
            end else if (load) begin
                pend_data <= data;
                pend_dp   <= dp_in;
                pend      <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:1] digit_empty;
    logic [3:1] tail_empty;

    // A digit is "empty" when its nibble is zero and its point is off. Digit k
    // blanks only if every digit from k up to 3 is empty.
    always_comb begin
        digit_empty = 3'b000;
        for (int k = 1; k < 4; k++) begin
            digit_empty[k] = (disp_data[4*k +: 4] == 4'h0) && !disp_dp[k];
        end
        tail_empty[3] = digit_empty[3];
        tail_empty[2] = digit_empty[2] && tail_empty[3];
        tail_empty[1] = digit_empty[1] && tail_empty[2];
    end

    always_comb begin
        case (idx)
            2'd1:    slot_blank = tail_empty[1];
            2'd2:    slot_blank = tail_empty[2];
            2'd3:    slot_blank = tail_empty[3];
            default: slot_blank = 1'b0;
        endcase
    end
`else
    assign slot_blank = 1'b0;
`endif

    // Pure decode of the registered index and display register. The outputs
    // therefore move on the same edge as the index.
    always_comb begin
        an    = 4'b1111;
        x     = 4'h0;
        dp    = 1'b1;
        blank = slot_blank;
        if (!slot_blank) begin
            an = ~(4'b0001 << idx);
            x  = disp_data[{idx, 2'b00} +: 4];
            dp = ~disp_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns/1ps
// tb_seg_scan_mux
// Directed bench for seg_scan_mux with CLK_DIV=4. Expectations are queued
// up front, each stamped with the clock edge after which it must hold. A
// monitor process compares them at the following falling edge. An extra
// event lets the monitor sample immediately after an asynchronous reset.
module tb_seg_scan_mux;

    localparam int CLK_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [3:0]  x;
    logic        dp;
    logic        blank;
    logic        pend;

    typedef struct {
        int         stamp;
        logic [3:0] an;
        logic [3:0] x;
        logic       dp;
        logic       blank;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_count;
    event sample_now;

    seg_scan_mux #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .dp_in (dp_in),
        .an    (an),
        .x     (x),
        .dp    (dp),
        .blank (blank),
        .pend  (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the last reset release; used as expectation stamps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_count <= 0;
        else        edge_count <= edge_count + 1;
    end

    function automatic exp_t mk(input int s, input logic [3:0] a, input logic [3:0] xx,
                                input logic d, input logic b, input logic p);
        exp_t e;
        e.stamp = s; e.an = a; e.x = xx; e.dp = d; e.blank = b; e.pend = p;
        return e;
    endfunction

    // Upper digit over an all-zero top: blanked only with the blanking build.
    function automatic exp_t mk_hi(input int s, input logic [3:0] a, input logic p);
        if (LZB) return mk(s, 4'b1111, 4'h0, 1'b1, 1'b1, p);
        else     return mk(s, a, 4'h0, 1'b1, 1'b0, p);
    endfunction

    task automatic checkOutput(input exp_t e);
        total++;
        if ({an, x, dp, blank, pend} !== {e.an, e.x, e.dp, e.blank, e.pend}) begin
            bad++;
            $display("[TB] FAIL slot@%0d: got an=%b x=%h dp=%b blank=%b pend=%b, want an=%b x=%h dp=%b blank=%b pend=%b",
                     e.stamp, an, x, dp, blank, pend, e.an, e.x, e.dp, e.blank, e.pend);
        end
    endtask

    // Monitor: pops every expectation whose stamp has been reached.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_now);
            while (sb.size() > 0 && sb[0].stamp <= edge_count) begin
                e = sb.pop_front();
                if (e.stamp < edge_count) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL slot@%0d: missed, got edge=%0d want edge=%0d",
                             e.stamp, edge_count, e.stamp);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    // Drives inputs at the falling edge that follows rising edge at_edge.
    task automatic applyStimulus(input int at_edge, input logic ld,
                                 input logic [15:0] d, input logic [3:0] p);
        int n = 0;
        while (edge_count != at_edge && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (edge_count != at_edge) begin
            total++;
            bad++;
            $display("[TB] FAIL stim@%0d: got edge=%0d want edge=%0d", at_edge, edge_count, at_edge);
        end
        load  = ld;
        data  = d;
        dp_in = p;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        load  = 1'b1;
        data  = 16'hFFFF;
        dp_in = 4'hF;

        // Reset state and first tick CLK_DIV cycles after release
        sb.push_back(mk(0,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(1,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(3,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk_hi(4, 4'b1101, 1'b0));
        // 1234 loaded during digit 1, waits for the boundary at edge 16
        sb.push_back(mk_hi(5,  4'b1101, 1'b1));
        sb.push_back(mk_hi(15, 4'b0111, 1'b1));
        sb.push_back(mk(16, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(19, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(20, 4'b1101, 4'h3, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(24, 4'b1011, 4'h2, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(28, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(31, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b0));
        // AAAA then 5555 in one frame: 1234 stays until edge 48, then 5555
        sb.push_back(mk(32, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(33, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(41, 4'b1011, 4'h2, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(47, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(48, 4'b1110, 4'h5, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(52, 4'b1101, 4'h5, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(56, 4'b1011, 4'h5, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(60, 4'b0111, 4'h5, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(63, 4'b0111, 4'h5, 1'b1, 1'b0, 1'b0));
        // BEEF with dp0 loaded on the boundary cycle: shown at once, no pend
        sb.push_back(mk(64, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(65, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(68, 4'b1101, 4'hE, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(72, 4'b1011, 4'hE, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(76, 4'b0111, 4'hB, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(79, 4'b0111, 4'hB, 1'b1, 1'b0, 1'b1));
        // 0007 with dp2: digits 1 and 2 shown, digit 3 blank only with LZB
        sb.push_back(mk(80, 4'b1110, 4'h7, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(84, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(88, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk_hi(92, 4'b0111, 1'b0));
        sb.push_back(mk_hi(94, 4'b0111, 1'b1));

        // A LOAD held through reset must be discarded
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;
        data  = 16'h0000;
        dp_in = 4'h0;

        applyStimulus(4,  1'b1, 16'h1234, 4'b0000);
        applyStimulus(5,  1'b0, 16'h0000, 4'b0000);
        applyStimulus(32, 1'b1, 16'hAAAA, 4'b0000);
        applyStimulus(33, 1'b0, 16'h0000, 4'b0000);
        applyStimulus(39, 1'b1, 16'h5555, 4'b0000);
        applyStimulus(40, 1'b0, 16'h0000, 4'b0000);
        applyStimulus(63, 1'b1, 16'hBEEF, 4'b0001);
        applyStimulus(64, 1'b1, 16'h0007, 4'b0100);
        applyStimulus(65, 1'b0, 16'h0000, 4'b0000);
        applyStimulus(93, 1'b1, 16'h1111, 4'b0000);
        applyStimulus(94, 1'b0, 16'h0000, 4'b0000);

        // Mid-frame asynchronous reset, sampled between clock edges
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.push_back(mk(0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0));
        #1;
        -> sample_now;
        repeat (2) @(negedge clk);
        sb.push_back(mk(3, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk_hi(4, 4'b1101, 1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL slot@%0d: never sampled, got edge=%0d want edge=%0d",
                     e.stamp, edge_count, e.stamp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time=%0t want finish before timeout", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter: CLK_DIV, 50000, CLK cycles per digit slot (legal range >= 2).
REQ-002 SHALL have port: CLK  input  1  sole clock, rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: LOAD  input  1  one-cycle strobe; capture DATA/DP_IN.
REQ-005 SHALL have port: DATA  input  16  four hex digits; digit k = DATA[4k+3:4k].
REQ-006 SHALL have port: DP_IN  input  4  decimal-point request per digit, 1 = lit.
REQ-007 SHALL have port: AN  output  4  digit enables, active-low, at most one low.
REQ-008 SHALL have port: X  output  4  nibble of the active digit; drives the hex-to-segment decoder input.
REQ-009 SHALL have port: DP  output  1  decimal point of the active digit, active-low.
REQ-010 SHALL have port: BLANK  output  1  1 = current slot blanked.
REQ-011 SHALL have port: PEND  output  1  1 = captured value waiting for frame boundary.

Function
REQ-012 SHALL run a prescaler counting 0..CLK_DIV-1 and wrapping to 0; tick = prescaler at CLK_DIV-1.
REQ-013 SHALL advance a 2-bit digit index on each tick, 0->1->2->3->0; index held between ticks.
REQ-014 SHALL define the frame boundary as a tick with index 3 (index wraps to 0 on that edge).
REQ-015 SHALL hold a pending register (16+4 bits) plus PEND flag; LOAD=1 at an edge writes DATA/DP_IN into it and sets PEND.
REQ-016 SHALL, on repeated LOAD before a boundary, keep only the last captured value.
REQ-017 SHALL, at a frame boundary with PEND=1, copy pending into the display register and clear PEND on that edge.
REQ-018 SHALL, at a frame boundary with LOAD=1 in the same cycle, load DATA/DP_IN directly into the display register and leave PEND=0.
REQ-019 SHALL never change the display register except at a frame boundary (no mid-frame tearing).
REQ-020 SHALL drive AN/X/DP/BLANK as a pure decode of registered index and display register: AN = index-th bit low, X = display nibble[index], DP = ~display DP[index].
REQ-021 SHALL change AN, X and DP on the same edge as the index advance; latency from boundary edge to new data on digit 0 is zero cycles.

Reset
REQ-022 SHALL, while RST_N=0, asynchronously clear prescaler, index, display, pending and PEND.
REQ-023 SHALL present after reset: AN=4'b1110, X=4'h0, DP=1, BLANK=0, PEND=0.
REQ-024 SHALL discard a LOAD coinciding with RST_N=0; first tick comes CLK_DIV cycles after release.

Configuration
REQ-025 SHALL support macro LEADING_ZERO_BLANK_EN compiled in or out.
REQ-026 SHALL, with LEADING_ZERO_BLANK_EN defined, blank digit k (k=3..1) when display nibbles k..3 are all zero and display DP bits k..3 are all clear: AN=4'b1111, X=4'h0, DP=1, BLANK=1; digit 0 never blanked.
REQ-027 SHALL, without LEADING_ZERO_BLANK_EN, tie BLANK to 0 and never blank any digit.

Verification
REQ-028 SHALL cover: RST_N low mid-frame -> immediately AN=1110, X=0, DP=1, PEND=0; restart from index 0.
REQ-029 SHALL cover: CLK_DIV=4, LOAD DATA=16'h1234 at index 1 -> PEND=1 until boundary; then X=4/3/2/1 with AN=1110/1101/1011/0111, each held 4 cycles, PEND=0.
REQ-030 SHALL cover: LOAD 16'hAAAA then LOAD 16'h5555 within one frame -> next frame shows 5,5,5,5; AAAA never shown.
REQ-031 SHALL cover: LOAD 16'hBEEF, DP_IN=4'b0001 on the boundary cycle -> next edge X=F, AN=1110, DP=0, PEND=0.
REQ-032 SHALL cover: LEADING_ZERO_BLANK_EN defined, DATA=16'h0007, DP_IN=4'b0100 -> digit0 X=7 BLANK=0; digit1 X=0 shown (DP2 lit above); digit2 X=0 DP=0; digit3 AN=1111 BLANK=1.
REQ-033 SHALL cover: macro undefined, DATA=16'h0007 -> digit3 AN=0111, X=0, BLANK=0.
